// File: rtl/stall_mem_resp_pkg.sv
// Shared definitions for the multi-cycle data-memory responder and its users.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stall_mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int MEM_DW        = 16;
    localparam int DEF_AW        = 8;
    localparam int DEF_LAT       = 2;
    localparam int DEF_ALIGN_CHK = 1;

endpackage

// File: rtl/stall_mem_resp_if.sv
// Load/store request bus between the MA stage (master) and the memory responder (slave).
// Latency: n/a (wiring only).
// Backpressure: stall from the slave holds the master's request stable until done.
interface stall_mem_resp_if;
    import stall_mem_resp_pkg::*;

    logic [15:0]        addr;
    logic [MEM_DW-1:0]  data_in;
    logic               rd;
    logic               wr;
    logic [MEM_DW-1:0]  data_out;
    logic               done;
    logic               stall;
    logic               err;

    modport master (
        output addr, data_in, rd, wr,
        input  data_out, done, stall, err
    );

    modport slave (
        input  addr, data_in, rd, wr,
        output data_out, done, stall, err
    );
endinterface

// File: rtl/stall_mem_resp_mem_array.sv
// 2^AW x 16 word storage with synchronous write and a registered, holding read port.
// Latency: write and read both take effect at the enabling edge; rdata holds otherwise.
// Backpressure: none; the caller never enables read and write together.
module mem_array
    import stall_mem_resp_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     idx,
    input  logic [MEM_DW-1:0] wdata,
    output logic [MEM_DW-1:0] rdata
);

    logic [MEM_DW-1:0] mem [2**AW];

    // Storage and read register; reset wipes every word so aborted writes leave no trace.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[idx] <= wdata;
            end
            if (re) begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/stall_mem_resp.sv
// Multi-cycle data-memory responder: accepts one rd/wr request, commits it LAT cycles later.
// Latency: request seen in cycle 0 produces a one-cycle done (with err) in cycle LAT.
// Backpressure: stall is high from request arrival until the done cycle; inputs are latched.
module stall_mem_resp
    import stall_mem_resp_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int LAT       = DEF_LAT,
    parameter int ALIGN_CHK = DEF_ALIGN_CHK
) (
    input  logic            clk,
    input  logic            rst,
    stall_mem_resp_if.slave bus
);

    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [AW:0]       addr_q;
    logic [MEM_DW-1:0] data_q;
    logic              rd_q, wr_q, err_q;

    logic              req, req_err, accept, commit, live;
    logic [AW:0]       c_addr;
    logic [MEM_DW-1:0] c_data;
    logic              c_rd, c_wr, c_err;
    logic              stall, done, err;
    logic              unused_addr_hi;

    // High address bits only alias; they never reach the array.
    assign unused_addr_hi = ^bus.addr[15:AW+1];

    assign req     = bus.rd | bus.wr;
    assign req_err = (bus.rd & bus.wr) | ((ALIGN_CHK != 0) & bus.addr[0]);
    assign accept  = (state_q == IDLE) & req;
    assign commit  = (state_d == DONE);

    // With LAT=1 the commit edge is also the acceptance edge, so the live inputs are used.
    assign live   = (state_q == IDLE);
    assign c_addr = live ? bus.addr[AW:0] : addr_q;
    assign c_data = live ? bus.data_in    : data_q;
    assign c_rd   = live ? bus.rd         : rd_q;
    assign c_wr   = live ? bus.wr         : wr_q;
    assign c_err  = live ? req_err        : err_q;

    // State, latency counter and request latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q <= bus.addr[AW:0];
                data_q <= bus.data_in;
                rd_q   <= bus.rd;
                wr_q   <= bus.wr;
                err_q  <= req_err;
            end
        end
    end

    // Next state and handshake outputs; the illegal encoding recovers to IDLE flagging err.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        case (state_q)
            IDLE: begin
                stall = req;
                if (req) begin
                    if (LAT > 1) begin
                        state_d = BUSY;
                        cnt_d   = LAT_M1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                err     = 1'b1;
            end
        endcase
    end

    assign bus.stall = stall;
    assign bus.done  = done;
    assign bus.err   = err;

    mem_array #(.AW(AW)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (commit & c_wr & ~c_err),
        .re    (commit & c_rd & ~c_err),
        .idx   (c_addr[AW:1]),
        .wdata (c_data),
        .rdata (bus.data_out)
    );

endmodule
